stopwatch_up: RTL and testbench

Up-counting mm:ss stopwatch, the count-up counterpart of the preset countdown timer. Driven by the same 1 Hz clk_out domain, with the same four-BCD-digit output convention, so both blocks share the display path. Adds a start/pause/done state machine, a mode-selected target limit, and a lap-freeze display snapshot.

---
 rtl/stopwatch_up.sv | 108 ++++++++++
 tb/tb_stopwatch_up.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_up.sv
// Up-counting mm:ss stopwatch on the 1 Hz clk_out domain: four live BCD digits,
// a start/pause/done FSM, a mode-latched stop limit and a lap-freeze display.
module stopwatch_up (
    input  logic       clk_out,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clear,
    input  logic [1:0] mode,
    input  logic       lap,
    output logic [3:0] c0,
    output logic [3:0] c1,
    output logic [3:0] c2,
    output logic [3:0] c3,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       running,
    output logic       done,
    output logic       wrap
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] n0, n1, n2, n3;
    logic [3:0] s0, s1, s2, s3;
    logic       freeze, lap_q;
    logic [1:0] mode_q;
    logic       step, hit_limit, at_max, lap_toggle;

    // Ripple BCD increment of the live count
    always_comb begin
        n0 = c0;
        n1 = c1;
        n2 = c2;
        n3 = c3 + 4'd1;
        if (c3 == 4'd9) begin
            n3 = 4'd0;
            n2 = c2 + 4'd1;
            if (c2 == 4'd5) begin
                n2 = 4'd0;
                n1 = c1 + 4'd1;
                if (c1 == 4'd9) begin
                    n1 = 4'd0;
                    n0 = (c0 == 4'd9) ? 4'd0 : c0 + 4'd1;
                end
            end
        end
    end

    assign step      = (state == RUN) && en;
    assign at_max    = ({c0, c1, c2, c3} == 16'h9959);
    assign hit_limit = ((mode_q == 2'b00) && ({n0, n1, n2, n3} == 16'h3000)) ||
                       ((mode_q == 2'b01) && ({n0, n1, n2, n3} == 16'h1000));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = PAUSE;
                     else if (hit_limit) state_nxt = DONE;
            PAUSE:   if (en) state_nxt = RUN;
            default: state_nxt = DONE;
        endcase
    end

    // A lap edge on the edge that enters DONE is dropped so the limit stays visible
    assign lap_toggle = lap && !lap_q && ((state == RUN) || (state == PAUSE)) &&
                        (state_nxt != DONE);

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            {c0, c1, c2, c3} <= '0;
            {s0, s1, s2, s3} <= '0;
            freeze <= 1'b0;
            lap_q  <= 1'b0;
            mode_q <= 2'b00;
            wrap   <= 1'b0;
        end else if (clear) begin
            state  <= IDLE;
            {c0, c1, c2, c3} <= '0;
            {s0, s1, s2, s3} <= '0;
            freeze <= 1'b0;
            lap_q  <= lap;
            mode_q <= 2'b00;
            wrap   <= 1'b0;
        end else begin
            state <= state_nxt;
            lap_q <= lap;
            wrap  <= step && mode_q[1] && at_max;
            if ((state == IDLE) && en) mode_q <= mode;
            if (step) {c0, c1, c2, c3} <= {n0, n1, n2, n3};
            if ((state_nxt == DONE) && (state != DONE)) begin
                freeze <= 1'b0;
            end else if (lap_toggle) begin
                freeze <= !freeze;
                if (!freeze) {s0, s1, s2, s3} <= {c0, c1, c2, c3};
            end
        end
    end

    assign {d0, d1, d2, d3} = freeze ? {s0, s1, s2, s3} : {c0, c1, c2, c3};
    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_stopwatch_up.sv
// Directed bench for stopwatch_up: start/pause latency, limits, free-run wrap,
// lap freeze and latched-mode behaviour against hand-computed mm:ss values.
module tb_stopwatch_up;

    logic       clk_out = 1'b0;
    logic       rst_n, en, clear, lap;
    logic [1:0] mode;
    logic [3:0] c0, c1, c2, c3, d0, d1, d2, d3;
    logic       running, done, wrap;
    int         total = 0;
    int         bad = 0;

    wire [15:0] cv = {c0, c1, c2, c3};
    wire [15:0] dv = {d0, d1, d2, d3};

    stopwatch_up dut (
        .clk_out(clk_out), .rst_n(rst_n), .en(en), .clear(clear), .mode(mode), .lap(lap),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .running(running), .done(done), .wrap(wrap)
    );

    always #5 clk_out = ~clk_out;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_out);
            #1;
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0; en = 1'b0; clear = 1'b0; lap = 1'b0; mode = 2'b00;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (cv !== 16'h0000) begin bad++; $display("FAIL reset_c got=%h exp=0000", cv); end
        total++; if (dv !== 16'h0000) begin bad++; $display("FAIL reset_d got=%h exp=0000", dv); end
        total++; if ({running, done, wrap} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {running, done, wrap}); end
    endtask

    task automatic test_start_freerun;
        do_reset();
        mode = 2'b10; en = 1'b1;
        tick(1);
        total++; if ({running, cv} !== {1'b1, 16'h0000}) begin bad++; $display("FAIL start_edge got=%b/%h exp=1/0000", running, cv); end
        tick(60);
        total++; if (cv !== 16'h0100) begin bad++; $display("FAIL run_61 got=%h exp=0100", cv); end
        total++; if (dv !== 16'h0100) begin bad++; $display("FAIL run_61_d got=%h exp=0100", dv); end
    endtask

    task automatic test_wrap;
        do_reset();
        mode = 2'b11; en = 1'b1;
        tick(1 + 5999);
        total++; if ({cv, wrap} !== {16'h9959, 1'b0}) begin bad++; $display("FAIL pre_wrap got=%h/%b exp=9959/0", cv, wrap); end
        tick(1);
        total++; if ({cv, wrap, running, done} !== {16'h0000, 3'b110}) begin bad++; $display("FAIL wrap_edge got=%h/%b%b%b exp=0000/110", cv, wrap, running, done); end
        tick(1);
        total++; if ({cv, wrap} !== {16'h0001, 1'b0}) begin bad++; $display("FAIL post_wrap got=%h/%b exp=0001/0", cv, wrap); end
    endtask

    task automatic test_limit_10;
        do_reset();
        mode = 2'b01; en = 1'b1;
        tick(1 + 599);
        total++; if ({cv, done} !== {16'h0959, 1'b0}) begin bad++; $display("FAIL pre_10 got=%h/%b exp=0959/0", cv, done); end
        lap = 1'b1;
        tick(1);
        total++; if ({cv, done, running} !== {16'h1000, 2'b10}) begin bad++; $display("FAIL done_10 got=%h/%b%b exp=1000/10", cv, done, running); end
        total++; if (dv !== 16'h1000) begin bad++; $display("FAIL done_10_lap got=%h exp=1000", dv); end
        lap = 1'b0; en = 1'b0;
        tick(2);
        en = 1'b1; lap = 1'b1;
        tick(3);
        total++; if ({cv, dv, done} !== {16'h1000, 16'h1000, 1'b1}) begin bad++; $display("FAIL hold_10 got=%h/%h/%b exp=1000/1000/1", cv, dv, done); end
    endtask

    task automatic test_limit_30;
        do_reset();
        mode = 2'b00; en = 1'b1;
        tick(1 + 1798);
        lap = 1'b1;
        tick(1);
        total++; if ({cv, dv} !== {16'h2959, 16'h2958}) begin bad++; $display("FAIL freeze_30 got=%h/%h exp=2959/2958", cv, dv); end
        tick(1);
        total++; if ({cv, dv, done} !== {16'h3000, 16'h3000, 1'b1}) begin bad++; $display("FAIL done_30 got=%h/%h/%b exp=3000/3000/1", cv, dv, done); end
    endtask

    task automatic test_lap;
        do_reset();
        mode = 2'b10; en = 1'b1;
        tick(1 + 12);
        lap = 1'b1;
        tick(1);
        total++; if ({cv, dv} !== {16'h0013, 16'h0012}) begin bad++; $display("FAIL lap_capture got=%h/%h exp=0013/0012", cv, dv); end
        lap = 1'b0;
        tick(4);
        total++; if ({cv, dv} !== {16'h0017, 16'h0012}) begin bad++; $display("FAIL lap_hold got=%h/%h exp=0017/0012", cv, dv); end
        en = 1'b0; lap = 1'b1;
        tick(1);
        total++; if ({cv, dv, running} !== {16'h0017, 16'h0017, 1'b0}) begin bad++; $display("FAIL lap_release got=%h/%h/%b exp=0017/0017/0", cv, dv, running); end
    endtask

    task automatic test_pause;
        do_reset();
        mode = 2'b10; en = 1'b1;
        tick(1 + 5);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            total++; if ({cv, running} !== {16'h0005, 1'b0}) begin bad++; $display("FAIL pause_%0d got=%h/%b exp=0005/0", i, cv, running); end
        end
        en = 1'b1;
        tick(1);
        total++; if ({cv, running} !== {16'h0005, 1'b1}) begin bad++; $display("FAIL resume_edge got=%h/%b exp=0005/1", cv, running); end
        tick(1);
        total++; if (cv !== 16'h0006) begin bad++; $display("FAIL resume_inc got=%h exp=0006", cv); end
    endtask

    task automatic test_mode_latch_clear;
        do_reset();
        mode = 2'b00; en = 1'b1;
        tick(1 + 300);
        mode = 2'b01;
        tick(452);
        total++; if ({cv, done, running} !== {16'h1232, 2'b01}) begin bad++; $display("FAIL latched got=%h/%b%b exp=1232/01", cv, done, running); end
        lap = 1'b1;
        tick(1);
        lap = 1'b0;
        tick(1);
        total++; if ({cv, dv} !== {16'h1234, 16'h1232}) begin bad++; $display("FAIL pre_clear got=%h/%h exp=1234/1232", cv, dv); end
        clear = 1'b1;
        tick(1);
        total++; if ({cv, dv, running, done} !== {16'h0000, 16'h0000, 2'b00}) begin bad++; $display("FAIL clear got=%h/%h/%b%b exp=0000/0000/00", cv, dv, running, done); end
        clear = 1'b0; en = 1'b0;
        tick(1);
        en = 1'b1;
        tick(2);
        total++; if ({cv, dv} !== {16'h0001, 16'h0001}) begin bad++; $display("FAIL after_clear got=%h/%h exp=0001/0001", cv, dv); end
    endtask

    task automatic test_async_reset;
        do_reset();
        mode = 2'b10; en = 1'b1;
        tick(1 + 7);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({cv, running} !== {16'h0000, 1'b0}) begin bad++; $display("FAIL async_rst got=%h/%b exp=0000/0", cv, running); end
        rst_n = 1'b1;
        tick(1);
        total++; if ({cv, running} !== {16'h0000, 1'b1}) begin bad++; $display("FAIL rst_release got=%h/%b exp=0000/1", cv, running); end
    endtask

    initial begin
        test_reset();
        test_start_freerun();
        test_wrap();
        test_limit_10();
        test_limit_30();
        test_lap();
        test_pause();
        test_mode_latch_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
